// File: rtl/fb_fill_arbiter_if.sv
// Write-port bundle for the fill arbiter: CPU write bus, fill control, status, and the mem write port.
// The master modport drives requests; the slave modport (the arbiter) drives status and mem.
interface fb_fill_arbiter_if;
    logic        cpu_wen;
    logic [15:0] cpu_waddr;
    logic [15:0] cpu_wdata;
    logic        fill_start;
    logic        fill_abort;
    logic [7:0]  fill_x;
    logic [7:0]  fill_y;
    logic [7:0]  fill_w;
    logic [7:0]  fill_h;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        mem_wen;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;

    modport master (
        output cpu_wen, cpu_waddr, cpu_wdata,
        output fill_start, fill_abort, fill_x, fill_y, fill_w, fill_h, fill_color,
        input  fill_busy, fill_done, mem_wen, mem_waddr, mem_wdata
    );

    modport slave (
        input  cpu_wen, cpu_waddr, cpu_wdata,
        input  fill_start, fill_abort, fill_x, fill_y, fill_w, fill_h, fill_color,
        output fill_busy, fill_done, mem_wen, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/fb_fill_arbiter.sv
// Rectangle-fill engine sharing the single mem write port with the CPU.
// CPU writes always win; fill pixels are written only on cycles the CPU leaves idle.
module fb_fill_arbiter #(
    parameter logic [15:0] FB_BASE   = 16'hC000,
    parameter int          FB_W_LOG2 = 7,
    parameter int          FB_HEIGHT = 96
) (
    input  logic               clk,
    input  logic               reset,
    fb_fill_arbiter_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [8:0]  FB_W   = 9'(1 << FB_W_LOG2);
    localparam logic [8:0]  FB_H   = 9'(FB_HEIGHT);
    localparam logic [15:0] STRIDE = 16'(1 << FB_W_LOG2);

    logic [1:0]  state_reg, state_next;
    logic [8:0]  x0_reg, x0_next;
    logic [8:0]  cur_x_reg, cur_x_next;
    logic [8:0]  cur_y_reg, cur_y_next;
    logic [8:0]  x_end_reg, x_end_next;
    logic [8:0]  y_end_reg, y_end_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] row_addr_reg, row_addr_next;
    logic [11:0] color_reg, color_next;

    logic [8:0]  x_sum, y_sum, x_end_start, y_end_start;
    logic [15:0] start_addr;
    logic        start_empty;
    logic        fill_step;
    logic        x_more, y_more;

    // Clipping is done once at start; the sums are 9 bits so they cannot wrap.
    assign x_sum       = {1'b0, bus.fill_x} + {1'b0, bus.fill_w};
    assign y_sum       = {1'b0, bus.fill_y} + {1'b0, bus.fill_h};
    assign x_end_start = (x_sum > FB_W) ? FB_W : x_sum;
    assign y_end_start = (y_sum > FB_H) ? FB_H : y_sum;
    assign start_empty = (x_end_start <= {1'b0, bus.fill_x}) ||
                         (y_end_start <= {1'b0, bus.fill_y});
    assign start_addr  = FB_BASE + (16'(bus.fill_y) << FB_W_LOG2) + 16'(bus.fill_x);

    assign fill_step = (state_reg == ST_RUN) && !bus.cpu_wen && !bus.fill_abort;
    assign x_more    = (cur_x_reg + 9'd1) < x_end_reg;
    assign y_more    = (cur_y_reg + 9'd1) < y_end_reg;

    always_comb begin
        state_next    = state_reg;
        x0_next       = x0_reg;
        cur_x_next    = cur_x_reg;
        cur_y_next    = cur_y_reg;
        x_end_next    = x_end_reg;
        y_end_next    = y_end_reg;
        addr_next     = addr_reg;
        row_addr_next = row_addr_reg;
        color_next    = color_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.fill_start) begin
                    x0_next       = {1'b0, bus.fill_x};
                    cur_x_next    = {1'b0, bus.fill_x};
                    cur_y_next    = {1'b0, bus.fill_y};
                    x_end_next    = x_end_start;
                    y_end_next    = y_end_start;
                    addr_next     = start_addr;
                    row_addr_next = start_addr;
                    color_next    = bus.fill_color;
                    state_next    = start_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.fill_abort) begin
                    state_next = ST_IDLE;
                end else if (fill_step) begin
                    if (x_more) begin
                        cur_x_next = cur_x_reg + 9'd1;
                        addr_next  = addr_reg + 16'd1;
                    end else if (y_more) begin
                        cur_x_next    = x0_reg;
                        cur_y_next    = cur_y_reg + 9'd1;
                        addr_next     = row_addr_reg + STRIDE;
                        row_addr_next = row_addr_reg + STRIDE;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            x0_reg       <= '0;
            cur_x_reg    <= '0;
            cur_y_reg    <= '0;
            x_end_reg    <= '0;
            y_end_reg    <= '0;
            addr_reg     <= '0;
            row_addr_reg <= '0;
            color_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            x0_reg       <= x0_next;
            cur_x_reg    <= cur_x_next;
            cur_y_reg    <= cur_y_next;
            x_end_reg    <= x_end_next;
            y_end_reg    <= y_end_next;
            addr_reg     <= addr_next;
            row_addr_reg <= row_addr_next;
            color_reg    <= color_next;
        end
    end

    // The fill path is gated by the live state register, so reset silences it immediately.
    always_comb begin
        bus.mem_wen   = 1'b0;
        bus.mem_waddr = 16'h0000;
        bus.mem_wdata = 16'h0000;
        if (bus.cpu_wen) begin
            bus.mem_wen   = 1'b1;
            bus.mem_waddr = bus.cpu_waddr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (fill_step) begin
            bus.mem_wen   = 1'b1;
            bus.mem_waddr = addr_reg;
            bus.mem_wdata = {4'h0, color_reg};
        end
    end

    assign bus.fill_busy = (state_reg == ST_RUN) || (state_reg == ST_DONE);
    assign bus.fill_done = (state_reg == ST_DONE);
endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Self-checking bench for fb_fill_arbiter: directed cases with literal expectations,
// then randomized traffic compared every cycle against a pixel-queue model.
module tb_fb_fill_arbiter;
    localparam int FB_WIDTH  = 128;
    localparam int FB_HEIGHT = 96;
    localparam int FB_BASE   = 'hC000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fb_fill_arbiter_if bus();

    fb_fill_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;

    // Model: the remaining pixel addresses of the active fill, plus a pending DONE cycle.
    logic [15:0] m_q[$];
    logic [11:0] m_color;
    bit          m_done;

    // Observation log for directed cases.
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          done_at;
    int          busy_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_start(input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] w, input logic [7:0] h,
                               input logic [11:0] c);
        int xe, ye;
        xe = int'(x) + int'(w);
        ye = int'(y) + int'(h);
        if (xe > FB_WIDTH)  xe = FB_WIDTH;
        if (ye > FB_HEIGHT) ye = FB_HEIGHT;
        m_q.delete();
        for (int yy = int'(y); yy < ye; yy++)
            for (int xx = int'(x); xx < xe; xx++)
                m_q.push_back(16'((FB_BASE + yy * FB_WIDTH + xx) & 'hFFFF));
        m_color = c;
        if (m_q.size() == 0) m_done = 1'b1;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic        e_wen;
        logic [15:0] e_addr, e_data;
        bit          running;
        @(negedge clk);
        running = (m_q.size() > 0);
        e_wen = 1'b0; e_addr = 16'h0; e_data = 16'h0;
        if (bus.cpu_wen) begin
            e_wen = 1'b1; e_addr = bus.cpu_waddr; e_data = bus.cpu_wdata;
        end else if (running && !bus.fill_abort) begin
            e_wen = 1'b1; e_addr = m_q[0]; e_data = {4'h0, m_color};
        end
        check("mem_wen",   32'(bus.mem_wen),   32'(e_wen));
        check("mem_waddr", 32'(bus.mem_waddr), 32'(e_addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(e_data));
        check("fill_busy", 32'(bus.fill_busy), 32'(running || m_done));
        check("fill_done", 32'(bus.fill_done), 32'(m_done));
        if (bus.mem_wen) begin
            wr_addr.push_back(bus.mem_waddr);
            wr_data.push_back(bus.mem_wdata);
        end
        if (bus.fill_done && done_at < 0) done_at = cyc - t0;
        if (bus.fill_busy) busy_cnt++;
        @(posedge clk);
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            if (bus.fill_abort) m_q.delete();
            else if (!bus.cpu_wen) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (bus.fill_start) begin
            model_start(bus.fill_x, bus.fill_y, bus.fill_w, bus.fill_h, bus.fill_color);
        end
        cyc++;
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_at  = -1;
        busy_cnt = 0;
    endtask

    task automatic run_fill(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h,
                            input logic [11:0] c);
        bus.fill_x = x; bus.fill_y = y; bus.fill_w = w; bus.fill_h = h;
        bus.fill_color = c;
        bus.fill_start = 1'b1;
        clear_log();
        t0 = cyc;
        cycle();
        bus.fill_start = 1'b0;
        // Parameters are don't-care after the start cycle.
        bus.fill_x = 8'($urandom); bus.fill_y = 8'($urandom);
        bus.fill_w = 8'($urandom); bus.fill_h = 8'($urandom);
        bus.fill_color = 12'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_mem_wen",   32'(bus.mem_wen),   32'h0);
        check("rst_mem_waddr", 32'(bus.mem_waddr), 32'h0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        check("rst_fill_busy", 32'(bus.fill_busy), 32'h0);
        check("rst_fill_done", 32'(bus.fill_done), 32'h0);
        m_q.delete();
        m_done = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic check_log(input string name, input logic [15:0] exp_a[$], input logic [15:0] exp_d[$]);
        check({name, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wr_addr.size(); i++) begin
            check({name, "_addr"}, 32'(wr_addr[i]), 32'(exp_a[i]));
            check({name, "_data"}, 32'(wr_data[i]), 32'(exp_d[i]));
        end
    endtask

    initial begin
        logic [15:0] ea[$];
        logic [15:0] ed[$];
        bus.cpu_wen = 1'b0; bus.cpu_waddr = 16'h0; bus.cpu_wdata = 16'h0;
        bus.fill_start = 1'b0; bus.fill_abort = 1'b0;
        bus.fill_x = 8'h0; bus.fill_y = 8'h0; bus.fill_w = 8'h0; bus.fill_h = 8'h0;
        bus.fill_color = 12'h0;
        m_done = 1'b0;
        clear_log();
        #1;
        check("reset_mem_wen",   32'(bus.mem_wen),   32'h0);
        check("reset_fill_busy", 32'(bus.fill_busy), 32'h0);
        check("reset_fill_done", 32'(bus.fill_done), 32'h0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        repeat (2) cycle();

        // Basic fill.
        run_fill(8'd2, 8'd3, 8'd3, 8'd2, 12'hF00);
        repeat (9) cycle();
        ea = '{16'hC182, 16'hC183, 16'hC184, 16'hC202, 16'hC203, 16'hC204};
        ed = '{16'h0F00, 16'h0F00, 16'h0F00, 16'h0F00, 16'h0F00, 16'h0F00};
        check_log("basic", ea, ed);
        check("basic_done_at", 32'(done_at), 32'd7);
        check("basic_busy_cnt", 32'(busy_cnt), 32'd7);

        // CPU steals the second RUN cycle.
        run_fill(8'd2, 8'd3, 8'd3, 8'd2, 12'hF00);
        cycle();
        bus.cpu_wen = 1'b1; bus.cpu_waddr = 16'h0010; bus.cpu_wdata = 16'h1234;
        cycle();
        bus.cpu_wen = 1'b0;
        repeat (8) cycle();
        ea = '{16'hC182, 16'h0010, 16'hC183, 16'hC184, 16'hC202, 16'hC203, 16'hC204};
        ed = '{16'h0F00, 16'h1234, 16'h0F00, 16'h0F00, 16'h0F00, 16'h0F00, 16'h0F00};
        check_log("steal", ea, ed);
        check("steal_done_at", 32'(done_at), 32'd8);

        // Clipping at the bottom-right corner.
        run_fill(8'd126, 8'd95, 8'd5, 8'd4, 12'h0AB);
        repeat (5) cycle();
        ea = '{16'hEFFE, 16'hEFFF};
        ed = '{16'h00AB, 16'h00AB};
        check_log("clip", ea, ed);
        check("clip_done_at", 32'(done_at), 32'd3);

        // Empty fills.
        run_fill(8'd10, 8'd10, 8'd0, 8'd5, 12'h111);
        repeat (3) cycle();
        check("empty_w_nwrites", 32'(wr_addr.size()), 32'd0);
        check("empty_w_done_at", 32'(done_at), 32'd1);
        check("empty_w_busy_cnt", 32'(busy_cnt), 32'd1);
        run_fill(8'd200, 8'd10, 8'd5, 8'd5, 12'h222);
        repeat (3) cycle();
        check("empty_x_nwrites", 32'(wr_addr.size()), 32'd0);
        check("empty_x_done_at", 32'(done_at), 32'd1);

        // Abort on the fourth RUN cycle.
        run_fill(8'd0, 8'd0, 8'd10, 8'd10, 12'h345);
        repeat (3) cycle();
        bus.fill_abort = 1'b1;
        cycle();
        bus.fill_abort = 1'b0;
        repeat (5) cycle();
        check("abort_nwrites", 32'(wr_addr.size()), 32'd3);
        check("abort_done_at", 32'(done_at), 32'hFFFF_FFFF);
        check("abort_busy_cnt", 32'(busy_cnt), 32'd4);

        // Reset mid-RUN.
        run_fill(8'd0, 8'd0, 8'd10, 8'd10, 12'h345);
        repeat (2) cycle();
        check("pre_reset_wen", 32'(bus.mem_wen), 32'h1);
        do_reset();
        repeat (3) cycle();
        check("reset_nwrites", 32'(wr_addr.size()), 32'd2);
        check("reset_done_at", 32'(done_at), 32'hFFFF_FFFF);

        // Start while busy is ignored.
        run_fill(8'd0, 8'd0, 8'd2, 8'd2, 12'h0CD);
        cycle();
        bus.fill_x = 8'd50; bus.fill_y = 8'd1; bus.fill_w = 8'd3; bus.fill_h = 8'd3;
        bus.fill_start = 1'b1;
        cycle();
        bus.fill_start = 1'b0;
        repeat (6) cycle();
        ea = '{16'hC000, 16'hC001, 16'hC080, 16'hC081};
        ed = '{16'h00CD, 16'h00CD, 16'h00CD, 16'h00CD};
        check_log("busy_start", ea, ed);
        check("busy_start_done_at", 32'(done_at), 32'd5);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                bus.cpu_wen = 1'b0; bus.fill_start = 1'b0; bus.fill_abort = 1'b0;
                do_reset();
            end
            bus.cpu_wen    = ($urandom_range(0, 3) == 0);
            bus.cpu_waddr  = 16'($urandom);
            bus.cpu_wdata  = 16'($urandom);
            bus.fill_start = ($urandom_range(0, 7) == 0);
            bus.fill_abort = ($urandom_range(0, 59) == 0);
            bus.fill_x     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 20));
            bus.fill_y     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(85, 255))  : 8'($urandom_range(0, 20));
            bus.fill_w     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            bus.fill_h     = 8'($urandom_range(0, 6));
            bus.fill_color = 12'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_fill_arbiter.md
# fb_fill_arbiter

Hardware rectangle-fill engine plus write-port arbiter sitting between `pipelined_cpu` and `mem`. It owns the single `mem` write port: CPU writes pass straight through with absolute priority. Fill writes of a solid 12-bit colour into a clipped rectangle of the framebuffer region use only the cycles the CPU leaves idle. This gives the CPU cheap screen clears and box draws without per-pixel stores.

## Interface
- `FB_BASE`, default 16'hC000: word address of framebuffer pixel (0,0).
- `FB_W_LOG2`, default 7: log2 of framebuffer width in pixels (width 128); row stride = 2^FB_W_LOG2 words.
- `FB_HEIGHT`, default 96: framebuffer height in rows.
- `clk` input 1: sole clock; all state on posedge.
- `reset` input 1: asynchronous, active-low; asserted low forces all state to reset values immediately.
- `cpu_wen` input 1: CPU write request.
- `cpu_waddr` input 16: CPU write address.
- `cpu_wdata` input 16: CPU write data.
- `fill_start` input 1: start request, sampled only in IDLE.
- `fill_abort` input 1: abort an active fill.
- `fill_x`, `fill_y` input 8 each: top-left pixel.
- `fill_w`, `fill_h` input 8 each: rectangle size in pixels.
- `fill_color` input 12: pixel value.
- `fill_busy` output 1: high in RUN and DONE.
- `fill_done` output 1: one-cycle completion pulse.
- `mem_wen`, `mem_waddr` (16), `mem_wdata` (16) outputs: to `mem` write port.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, `fill_busy`=0, `fill_done`=0, internal counters 0.
- Arbitration is combinational: `cpu_wen`=1 → `mem_wen`=1, `mem_waddr`=`cpu_waddr`, `mem_wdata`=`cpu_wdata`. Otherwise, in RUN, `mem_wen`=1, address = current fill address, data = {4'h0, latched colour}. Otherwise `mem_wen`=0 and addr/data = 0.
- IDLE + `fill_start`:
  - Latch x0, y0, colour.
  - Compute x_end = min(x0+w, 2^FB_W_LOG2) and y_end = min(y0+h, FB_HEIGHT), 9-bit unsigned with no wrap.
  - If x_end<=x0 or y_end<=y0 (w=0, h=0, or fully off-screen), go to DONE with no writes.
  - Else set cur_x=x0, cur_y=y0, addr = FB_BASE + (y0<<FB_W_LOG2) + x0 (16-bit, modulo 2^16), and go to RUN.
- RUN, fill write cycle (`cpu_wen`=0, `fill_abort`=0):
  - Write the pixel.
  - If cur_x+1 < x_end: cur_x++ and addr++.
  - Else if cur_y+1 < y_end: cur_x=x0, cur_y++, addr = row start + stride.
  - Else go to DONE.
- RUN with `cpu_wen`=1: the fill is stalled; its counters hold and the CPU write proceeds.
- `fill_abort` in RUN: suppresses that cycle's fill write (a CPU write still passes) and goes to IDLE next cycle. No `fill_done` pulse. Ignored in IDLE and DONE.
- DONE: `fill_done`=1 for exactly this cycle, then IDLE.
- `fill_start` in RUN or DONE is ignored; no queueing. Parameter inputs are don't-care except in the start cycle.
- Reset low mid-fill: immediately IDLE, fill writes stop that instant, no `fill_done`.

## Timing
- CPU path latency: 0 cycles, combinational, never stalled; the CPU has no backpressure.
- First fill write occurs in the cycle after `fill_start` is sampled.
- A clipped area of N pixels takes N + (CPU-write cycles during RUN) cycles in RUN, then one DONE cycle.
- Empty fill: DONE in the cycle after start, so `fill_done` appears 1 cycle after start.
- `fill_busy` rises the cycle after start and falls the cycle after `fill_done`.
- The earliest next accepted start is the cycle after DONE.
- `fill_busy` and `fill_done` are registered state decodes.

## Test plan
- Basic fill:
  - Stimulus: x=2, y=3, w=3, h=2, colour 12'hF00, no CPU writes.
  - Required: `mem_wen` on 6 consecutive cycles to C182, C183, C184, C202, C203, C204, each with data 16'h0F00.
  - Required: `fill_done` pulse on the 7th cycle after start; `fill_busy` high cycles 1-7.
- CPU steal:
  - Stimulus: same fill, with `cpu_wen`=1, addr 16'h0010, data 16'h1234 on the 2nd RUN cycle.
  - Required: that cycle writes 0010/1234; C183 moves to the next cycle; all 6 pixel writes still occur; `fill_done` arrives 1 cycle later than in the basic fill.
- Clipping:
  - Stimulus: x=126, w=5, y=95, h=4.
  - Required: exactly two writes, EFFE and EFFF, then `fill_done`.
- Empty fills:
  - Stimulus: w=0; then separately x=200.
  - Required: zero fill writes; `fill_done` 1 cycle after start.
- Abort and reset:
  - Stimulus: 10x10 fill, `fill_abort` on the 4th RUN cycle.
  - Required: exactly 3 pixel writes, no `fill_done`, IDLE next cycle.
  - Stimulus: repeat the fill with `reset` low mid-RUN.
  - Required: `mem_wen` drops immediately and all outputs are 0.
- Start while busy:
  - Stimulus: second `fill_start` with different parameters during RUN.
  - Required: ignored; only the first rectangle is written.
